// File: rtl/csr_trap_ctrl_pkg.sv
// Shared definitions for the CSR port sequencer: CSR addresses, op encodings,
// mstatus field positions, sequencer states and mstatus rewrite helpers.
package csr_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    localparam int MS_MIE    = 3;
    localparam int MS_MPIE   = 7;
    localparam int MS_MPP_LO = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T_MEPC,
        ST_T_MCAUSE,
        ST_T_MSRD,
        ST_T_MSWR,
        ST_R_MSRD,
        ST_R_MSWR,
        ST_REDIR
    } state_e;

    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms,
                                                    input logic [1:0]  mpp);
        logic [31:0] r;
        r                  = ms;
        r[MS_MPIE]         = ms[MS_MIE];
        r[MS_MIE]          = 1'b0;
        r[MS_MPP_LO +: 2]  = mpp;
        return r;
    endfunction

    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms,
                                                    input logic [1:0]  mpp);
        logic [31:0] r;
        r                  = ms;
        r[MS_MIE]          = ms[MS_MPIE];
        r[MS_MPIE]         = 1'b1;
        r[MS_MPP_LO +: 2]  = mpp;
        return r;
    endfunction

endpackage

// File: rtl/csr_trap_ctrl_trap_target_calc.sv
// Trap vector target: direct mode jumps to the mtvec base, vectored mode
// (mtvec[1:0]==01) offsets interrupts by 4*cause.
module trap_target_calc (
    input  logic [31:0] mtvec,
    input  logic [31:0] cause,
    output logic [31:0] target
);
    logic [31:0] base;

    assign base = mtvec & ~32'h3;

    // cause<<2 drops bit 31 (interrupt flag) and keeps the sum mod 2^32
    always_comb begin
        target = base;
        if (mtvec[1:0] == 2'b01 && cause[31])
            target = base + (cause << 2);
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Owns the CSR unit access port: passes pipeline CSR instructions through in
// IDLE and sequences trap entry / MRET writes, then issues a PC redirect.
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter logic [1:0] MPP_M = 2'b11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        csr_req_i,
    input  logic [1:0]  csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_src_i,
    output logic        csr_gnt_o,
    output logic [31:0] csr_rdata_o,
    input  logic        trap_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic        mret_i,
    output logic        csr_en_o,
    output logic [1:0]  csr_op_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    input  logic [31:0] csr_rdata_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        busy_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);
    state_e      state_q, state_d;
    logic [31:0] cause_q, pc_q, mstatus_q, target_q;
    logic [31:0] trap_target;

    trap_target_calc u_target (
        .mtvec  (mtvec_i),
        .cause  (cause_q),
        .target (trap_target)
    );

    assign busy_o = (state_q != ST_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cause_q   <= '0;
            pc_q      <= '0;
            mstatus_q <= '0;
            target_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && trap_i) begin
                cause_q <= trap_cause_i;
                pc_q    <= trap_pc_i & ~32'h3;
            end
            if (state_q == ST_T_MSRD || state_q == ST_R_MSRD)
                mstatus_q <= csr_rdata_i;
            if (state_q == ST_T_MSWR)
                target_q <= trap_target;
            if (state_q == ST_R_MSWR)
                target_q <= mepc_i & ~32'h3;
        end
    end

    always_comb begin
        state_d       = state_q;
        csr_en_o      = 1'b0;
        csr_op_o      = OP_NONE;
        csr_addr_o    = '0;
        csr_wdata_o   = '0;
        csr_gnt_o     = 1'b0;
        csr_rdata_o   = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (trap_i) begin
                    state_d = ST_T_MEPC;
                end else if (mret_i) begin
                    state_d = ST_R_MSRD;
                end else if (csr_req_i) begin
                    csr_en_o    = 1'b1;
                    csr_op_o    = csr_op_i;
                    csr_addr_o  = csr_addr_i;
                    csr_wdata_o = csr_src_i;
                    csr_gnt_o   = 1'b1;
                    csr_rdata_o = csr_rdata_i;
                end
            end
            ST_T_MEPC: begin
                csr_en_o    = 1'b1;
                csr_op_o    = OP_RW;
                csr_addr_o  = CSR_MEPC;
                csr_wdata_o = pc_q;
                state_d     = ST_T_MCAUSE;
            end
            ST_T_MCAUSE: begin
                csr_en_o    = 1'b1;
                csr_op_o    = OP_RW;
                csr_addr_o  = CSR_MCAUSE;
                csr_wdata_o = cause_q;
                state_d     = ST_T_MSRD;
            end
            // RS with zero write data reads mstatus without modifying it
            ST_T_MSRD, ST_R_MSRD: begin
                csr_en_o   = 1'b1;
                csr_op_o   = OP_RS;
                csr_addr_o = CSR_MSTATUS;
                state_d    = (state_q == ST_T_MSRD) ? ST_T_MSWR : ST_R_MSWR;
            end
            ST_T_MSWR: begin
                csr_en_o    = 1'b1;
                csr_op_o    = OP_RW;
                csr_addr_o  = CSR_MSTATUS;
                csr_wdata_o = mstatus_on_trap(mstatus_q, MPP_M);
                state_d     = ST_REDIR;
            end
            ST_R_MSWR: begin
                csr_en_o    = 1'b1;
                csr_op_o    = OP_RW;
                csr_addr_o  = CSR_MSTATUS;
                csr_wdata_o = mstatus_on_mret(mstatus_q, MPP_M);
                state_d     = ST_REDIR;
            end
            ST_REDIR: begin
                redirect_o    = 1'b1;
                redirect_pc_o = target_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Sequencer that owns the single access port of the machine-mode CSR unit and shares it between the pipeline's CSR instructions and the trap/return machinery. On a synchronous exception or interrupt it performs the architectural trap-entry sequence (mepc, mcause, mstatus update, redirect to mtvec); on MRET it performs the mstatus restore and redirects to mepc. It sits between the execute stage and the CSR unit and stalls the pipeline while a sequence is in flight.

## Interface
- `MPP_M`, default 2'b11, value written to mstatus.MPP on trap entry (M-mode only core).
- `clk_i` in 1: core clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `csr_req_i` in 1: pipeline CSR instruction request.
- `csr_op_i` in 2: 01 RW, 10 RS, 11 RC.
- `csr_addr_i` in 12: target CSR address.
- `csr_src_i` in 32: operand (rs1 value or zero-extended uimm, already selected).
- `csr_gnt_o` out 1: request accepted this cycle.
- `csr_rdata_o` out 32: old CSR value for the granted instruction.
- `trap_i` in 1: trap request (held until `busy_o` seen).
- `trap_cause_i` in 32: mcause value, bit 31 = interrupt.
- `trap_pc_i` in 32: PC to save in mepc.
- `mret_i` in 1: MRET request.
- `csr_en_o` out 1, `csr_op_o` out 2, `csr_addr_o` out 12, `csr_wdata_o` out 32: drive CSR unit (source select fixed to register operand).
- `csr_rdata_i` in 32: CSR unit combinational read data.
- `mtvec_i` in 32, `mepc_i` in 32: CSR unit direct outputs.
- `busy_o` out 1: sequence in flight; pipeline must stall.
- `redirect_o` out 1: one-cycle PC redirect strobe.
- `redirect_pc_o` out 32: redirect target.

## Operation
- States: IDLE, T_MEPC, T_MCAUSE, T_MSRD, T_MSWR, R_MSRD, R_MSWR, REDIR.
- IDLE arbitration, fixed priority: `trap_i` > `mret_i` > `csr_req_i`. Loser not granted; requester retries.
- CSR instruction (IDLE only): combinational pass-through of op/addr/src to CSR port, `csr_en_o`=1, `csr_gnt_o`=1, `csr_rdata_o`=`csr_rdata_i`; state stays IDLE.
- Trap accept: latch cause and pc; go T_MEPC.
  - T_MEPC: RW 0x341 with latched pc (bits 1:0 forced 0). -> T_MCAUSE.
  - T_MCAUSE: RW 0x342 with latched cause. -> T_MSRD.
  - T_MSRD: read 0x300 (op RS, wdata 0, no change); capture `csr_rdata_i`. -> T_MSWR.
  - T_MSWR: RW 0x300 with captured value, MPIE(7)=old MIE(3), MIE=0, MPP(12:11)=`MPP_M`. Compute target: mtvec mode 01 and cause[31]=1 -> {mtvec[31:2],2'b00} + 4*cause[30:0] (mod 2^32); otherwise {mtvec[31:2],2'b00}. -> REDIR.
- MRET accept: R_MSRD (capture mstatus) -> R_MSWR: RW 0x300 with MIE=old MPIE, MPIE=1, MPP=`MPP_M`; target = `mepc_i` with bits 1:0 cleared. -> REDIR.
- REDIR: `redirect_o`=1, `redirect_pc_o`=target. -> IDLE.
- `busy_o`=1 in every state except IDLE. `csr_gnt_o`=0 whenever not IDLE.
- Outside accesses, `csr_en_o`=0 and op/addr/wdata = 0.

## Timing
- Reset: state IDLE; all latched registers 0; `busy_o`, `redirect_o`, `csr_en_o`, `csr_gnt_o` 0; `redirect_pc_o` 0.
- CSR instruction: 0-cycle grant and read; write lands at the clock edge of the grant cycle.
- Trap accepted at cycle t: CSR writes at t+1 (mepc), t+2 (mcause), read t+3, write t+4; `redirect_o` at t+5; IDLE at t+6.
- MRET accepted at t: read t+1, write t+2, `redirect_o` t+3.
- `trap_i`/`mret_i` arriving while busy are ignored; requester holds until IDLE.
- Simultaneous trap and mret in IDLE: trap taken, mret dropped by the pipeline (flushed).
- Reset mid-sequence: immediate return to IDLE, partial CSR writes are not rolled back.

## Structure
- Shared package: CSR addresses (0x300, 0x341, 0x342, 0x305), op encodings, mstatus bit positions, state encoding.
- One natural sub-module: `trap_target_calc` (combinational mtvec direct/vectored target).

## Test plan
- CSR RW 0x340 src 0xDEADBEEF in IDLE -> grant same cycle, later read returns 0xDEADBEEF.
- Trap cause 0x2, pc 0x100, mtvec 0x8000, mstatus 0x8 -> mepc 0x100, mcause 0x2, mstatus 0x1880, redirect 0x8000 at t+5.
- Interrupt cause 0x8000000B, mtvec 0x8001 -> redirect 0x802C.
- MRET with mstatus 0x1880, mepc 0x104 -> mstatus 0x1888, redirect 0x104 at t+3.
- Trap and csr_req in same cycle -> csr_gnt_o 0 for 6 cycles, then granted.
- rst_i pulsed at t+2 of trap -> busy_o 0 immediately, no redirect, mepc holds 0x100.
